io_bridge: RTL and testbench
============================

# io_bridge

Memory-mapped I/O bridge sitting directly downstream of the CPU core's external memory bus (`mem_a`/`mem_dout`/`mem_wr`), beside the 128 KB RAM. It decodes accesses with `mem_a[17:16]==2'b11`. It buffers UART output bytes in a FIFO and drives `io_buffer_full` back to the core. It also serves input-byte and cycle-counter reads and sequences program stop.

## Interface
Parameters:
- `FIFO_AW`, 4: log2 of TX FIFO depth (depth 16).
- `FULL_MARGIN`, 2: `io_buffer_full` asserts when free slots ≤ `FULL_MARGIN`.

Ports:
- `clk_in`, in, 1: system clock.
- `rst_in`, in, 1: reset. One clock; reset is asynchronous and active-low.
- `rdy_in`, in, 1: bus-side enable.
- `mem_a`, in, 32: core address bus.
- `mem_dout`, in, 8: core write data.
- `mem_wr`, in, 1: 1 = write.
- `io_din`, out, 8: registered read data for I/O reads.
- `io_sel`, out, 1: registered. High when the previous accepted cycle was an I/O read; the top muxes `io_din` over RAM data with it.
- `io_buffer_full`, out, 1: FIFO near-full back-pressure to the core.
- `rx_valid`, in, 1: UART RX byte available.
- `rx_data`, in, 8: UART RX byte.
- `rx_ack`, out, 1: one-cycle pulse; RX byte consumed.
- `tx_valid`, out, 1: FIFO head valid.
- `tx_data`, out, 8: FIFO head byte.
- `tx_ready`, in, 1: UART TX accepts a byte.
- `program_done`, out, 1: sticky; stop sequence finished.
- `overflow_err`, out, 1: sticky; a push was dropped.

## Operation
- Bus cycle accepted when `rdy_in` is high and `mem_a[17:16]==2'b11`. When `rdy_in` is low, bus inputs are ignored and the counter freezes. The TX drain continues.
- Write to offset 0 (`mem_a[2:0]==0`):
  - `mem_dout != 0` pushes the byte.
  - `8'h00` is ignored.
- Write to offset 4: pushes `8'h00` and moves the FSM RUN→STOPPING.
- Read offset 0:
  - If `rx_valid` is high: `io_din <= rx_data`, and `rx_ack` pulses in the same cycle.
  - Otherwise `io_din <= 0`.
- Read offset 4:
  - Snapshots the 32-bit cycle counter.
  - Returns byte 0 of the live count.
- Reads of offsets 5–7 return snapshot bytes 1–3, so a dword read is coherent.
- Other offsets: writes are ignored; reads return 0.
- Cycle counter: 32-bit, +1 every cycle `rdy_in` is high, wraps at 2^32.
- FIFO: circular buffer, `FIFO_AW`-bit pointers, `FIFO_AW+1`-bit count.
  - Pop when `tx_valid && tx_ready`.
  - A push is accepted if count < depth, or if a pop occurs in the same cycle.
  - Otherwise the byte is dropped and `overflow_err` is set.
- `io_buffer_full = (depth - count) <= FULL_MARGIN`. It is combinational from the count register; the margin covers writes already in flight in the core.
- FSM:
  - RUN: normal operation.
  - STOPPING: all further writes are ignored; reads are still served.
  - DONE: entered from STOPPING when the FIFO is empty and no pop is occurring that cycle. `program_done = 1` in DONE.
  - DONE is terminal until reset.

## Timing
- Reset values: all outputs 0, FSM = RUN, counter = 0, FIFO empty.
- Reset asserted mid-operation discards FIFO contents immediately.
- Read latency is 1 cycle: `io_din`/`io_sel` are valid in the cycle after the read is presented, matching RAM latency.
- Write effect: a pushed byte appears on `tx_valid`/`tx_data` the next cycle.
- `tx_data` holds stable while `tx_valid && !tx_ready`.
- `io_buffer_full` updates the cycle after the push or pop that changes the count.
- Simultaneous push and pop at count = depth: both happen, count unchanged, no error.
- Pointer wrap from depth-1 to 0 is seamless.

## Structure
- Shared package/defines: `IO_BASE_SEL` (`2'b11`), offsets `IO_PORT` (0) and `IO_CLK` (4), FSM state encodings (`IOB_RUN`, `IOB_STOPPING`, `IOB_DONE`).
- One sub-module: `io_tx_fifo` (parameterised sync FIFO with push/pop/count/full/empty). Decode, counter and FSM stay in `io_bridge`.

## Test plan
- Write `8'h41`, `8'h42` to 0x30000 with `tx_ready = 1` → `tx_data` shows 0x41 then 0x42 on consecutive cycles; a write of `8'h00` produces no `tx_valid`.
- Hold `tx_ready = 0` and write 14 bytes → `io_buffer_full` rises after the 14th push. Write 2 more → FIFO full, no error. 17th write → `overflow_err = 1` and the byte is absent from the drain order.
- Full FIFO plus a same-cycle write with `tx_ready = 1` → count stays 16, `overflow_err` stays 0.
- Run 1000 cycles, then read 0x30004–0x30007 on consecutive cycles → bytes reassemble to the snapshot value (≈1000), `io_sel = 1` each following cycle. Drop `rdy_in` for 10 cycles → counter does not advance.
- `rx_valid = 1`, `rx_data = 8'h5A`, read 0x30000 → `rx_ack` pulse, next-cycle `io_din = 0x5A`. With `rx_valid = 0` → `io_din = 0`.
- Queue 3 bytes, write 0x30004, then write `8'h43` → 3 bytes plus `8'h00` drain and `8'h43` is never sent. `program_done = 1` the cycle after the FIFO empties. Assert reset mid-drain → `tx_valid`, `program_done` and `overflow_err` all 0 immediately.

Source files
------------

// File: rtl/io_bridge_pkg.sv
// io_bridge_pkg: shared decode constants and FSM encoding for the I/O bridge.
//   IO_BASE_SEL : mem_a[17:16] value that selects the I/O window
//   IO_PORT     : byte offset of the UART data port
//   IO_CLK      : byte offset of the stop / cycle-counter port
package io_bridge_pkg;
  localparam logic [1:0] IO_BASE_SEL = 2'b11;
  localparam logic [2:0] IO_PORT     = 3'd0;
  localparam logic [2:0] IO_CLK      = 3'd4;

  typedef enum logic [1:0] {
    IOB_RUN      = 2'd0,
    IOB_STOPPING = 2'd1,
    IOB_DONE     = 2'd2
  } iob_state_e;
endpackage

// File: rtl/io_tx_fifo.sv
// io_tx_fifo: synchronous circular-buffer FIFO for UART TX bytes.
//   clk_in/rst_in : clock, async active-low reset (empties the FIFO)
//   i_push/i_din  : push request and byte
//   i_pop         : pop request (ignored when empty)
//   o_dout        : head byte, 0 when empty
//   o_count       : occupancy, AW+1 bits
//   o_full/o_empty: status flags
//   o_drop        : push request that could not be accepted this cycle
module io_tx_fifo #(
  parameter int AW = 4
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        i_push,
  input  logic [7:0]  i_din,
  input  logic        i_pop,
  output logic [7:0]  o_dout,
  output logic [AW:0] o_count,
  output logic        o_full,
  output logic        o_empty,
  output logic        o_drop
);
  localparam logic [AW:0] DEPTH_V = {1'b1, {AW{1'b0}}};

  logic [7:0]    r_mem [1<<AW];
  logic [AW-1:0] r_wr, r_rd;
  logic [AW:0]   r_count;
  logic          w_pop, w_push_ok;

  assign o_count = r_count;
  assign o_full  = (r_count == DEPTH_V);
  assign o_empty = (r_count == '0);
  assign w_pop   = i_pop && !o_empty;
  // A pop in the same cycle frees the slot the push needs, so a full FIFO
  // can still take the byte.
  assign w_push_ok = i_push && (!o_full || w_pop);
  assign o_drop    = i_push && !w_push_ok;
  assign o_dout    = o_empty ? 8'h00 : r_mem[r_rd];

  // Storage is not reset; occupancy alone defines what is valid.
  always_ff @(posedge clk_in) begin
    if (w_push_ok) r_mem[r_wr] <= i_din;
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      r_wr    <= '0;
      r_rd    <= '0;
      r_count <= '0;
    end else begin
      if (w_push_ok) r_wr <= r_wr + 1'b1;
      if (w_pop)     r_rd <= r_rd + 1'b1;
      case ({w_push_ok, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end
endmodule

// File: rtl/io_bridge.sv
// io_bridge: memory-mapped I/O next to the core's RAM (mem_a[17:16]==2'b11).
//   clk_in, rst_in (async active-low), rdy_in (bus enable)
//   mem_a/mem_dout/mem_wr : core bus
//   io_din/io_sel         : registered read data and its mux select
//   io_buffer_full        : TX FIFO near-full back-pressure
//   rx_valid/rx_data/rx_ack : UART RX byte handshake
//   tx_valid/tx_data/tx_ready : UART TX FIFO head
//   program_done, overflow_err : sticky status
import io_bridge_pkg::*;

module io_bridge #(
  parameter int FIFO_AW     = 4,
  parameter int FULL_MARGIN = 2
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        rdy_in,
  input  logic [31:0] mem_a,
  input  logic [7:0]  mem_dout,
  input  logic        mem_wr,
  output logic [7:0]  io_din,
  output logic        io_sel,
  output logic        io_buffer_full,
  input  logic        rx_valid,
  input  logic [7:0]  rx_data,
  output logic        rx_ack,
  output logic        tx_valid,
  output logic [7:0]  tx_data,
  input  logic        tx_ready,
  output logic        program_done,
  output logic        overflow_err
);
  localparam logic [FIFO_AW:0] DEPTH_V  = {1'b1, {FIFO_AW{1'b0}}};
  localparam logic [FIFO_AW:0] MARGIN_V = FULL_MARGIN[FIFO_AW:0];

  iob_state_e r_state, w_state_nxt;
  logic [31:0] r_cnt, r_snap;
  logic [7:0]  r_din, w_rd_data, w_push_data;
  logic        r_sel, r_ovf;
  logic        w_acc, w_rd, w_wr, w_push, w_stop, w_drop, w_empty, w_full;
  logic [2:0]  w_off;
  logic [FIFO_AW:0] w_count, w_free;
  logic        w_unused;

  assign w_unused = &{1'b0, mem_a[31:18], mem_a[15:3], w_full};

  assign w_acc = rdy_in && (mem_a[17:16] == IO_BASE_SEL);
  assign w_off = mem_a[2:0];
  assign w_rd  = w_acc && !mem_wr;
  // Once the stop port has been hit, no write may enter the FIFO.
  assign w_wr  = w_acc && mem_wr && (r_state == IOB_RUN);

  // A data-port write of 0 is a no-op; the stop port queues the 0 terminator.
  assign w_push = w_wr && (((w_off == IO_PORT) && (mem_dout != 8'h00)) || (w_off == IO_CLK));
  assign w_push_data = (w_off == IO_CLK) ? 8'h00 : mem_dout;
  assign w_stop = w_wr && (w_off == IO_CLK);

  assign rx_ack = w_rd && (w_off == IO_PORT) && rx_valid;

  // Offset 4 returns the live count and snapshots it; 5..7 come from the
  // snapshot so a dword read sees one consistent value.
  always_comb begin
    w_rd_data = 8'h00;
    case (w_off)
      IO_PORT: w_rd_data = rx_valid ? rx_data : 8'h00;
      IO_CLK:  w_rd_data = r_cnt[7:0];
      3'd5:    w_rd_data = r_snap[15:8];
      3'd6:    w_rd_data = r_snap[23:16];
      3'd7:    w_rd_data = r_snap[31:24];
      default: w_rd_data = 8'h00;
    endcase
  end

  io_tx_fifo #(.AW(FIFO_AW)) u_fifo (
    .clk_in  (clk_in),
    .rst_in  (rst_in),
    .i_push  (w_push),
    .i_din   (w_push_data),
    .i_pop   (tx_ready),
    .o_dout  (tx_data),
    .o_count (w_count),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_drop  (w_drop)
  );

  assign tx_valid       = !w_empty;
  assign w_free         = DEPTH_V - w_count;
  assign io_buffer_full = (w_free <= MARGIN_V);

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      r_cnt  <= '0;
      r_snap <= '0;
      r_din  <= '0;
      r_sel  <= 1'b0;
      r_ovf  <= 1'b0;
    end else begin
      if (rdy_in) begin
        r_cnt <= r_cnt + 32'd1;
        r_sel <= w_rd;
        if (w_rd) r_din <= w_rd_data;
        if (w_rd && (w_off == IO_CLK)) r_snap <= r_cnt;
      end
      if (w_drop) r_ovf <= 1'b1;
    end
  end

  assign io_din       = r_din;
  assign io_sel       = r_sel;
  assign overflow_err = r_ovf;

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) r_state <= IOB_RUN;
    else         r_state <= w_state_nxt;
  end

  // An empty FIFO cannot pop, so !tx_valid covers "empty and no pop".
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IOB_RUN:      if (w_stop) w_state_nxt = IOB_STOPPING;
      IOB_STOPPING: if (!tx_valid) w_state_nxt = IOB_DONE;
      IOB_DONE:     w_state_nxt = IOB_DONE;
      default:      w_state_nxt = IOB_RUN;
    endcase
  end

  assign program_done = (r_state == IOB_DONE);
endmodule

// File: tb/tb_io_bridge.sv
module tb_io_bridge;
  logic        clk_in = 1'b0;
  logic        rst_in = 1'b0;
  logic        rdy_in = 1'b1;
  logic [31:0] mem_a = '0;
  logic [7:0]  mem_dout = '0;
  logic        mem_wr = 1'b0;
  logic [7:0]  io_din;
  logic        io_sel;
  logic        io_buffer_full;
  logic        rx_valid = 1'b0;
  logic [7:0]  rx_data = '0;
  logic        rx_ack;
  logic        tx_valid;
  logic [7:0]  tx_data;
  logic        tx_ready = 1'b0;
  logic        program_done;
  logic        overflow_err;

  int n_pass = 0;
  int n_chk  = 0;

  io_bridge #(.FIFO_AW(4), .FULL_MARGIN(2)) dut (
    .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in),
    .mem_a(mem_a), .mem_dout(mem_dout), .mem_wr(mem_wr),
    .io_din(io_din), .io_sel(io_sel), .io_buffer_full(io_buffer_full),
    .rx_valid(rx_valid), .rx_data(rx_data), .rx_ack(rx_ack),
    .tx_valid(tx_valid), .tx_data(tx_data), .tx_ready(tx_ready),
    .program_done(program_done), .overflow_err(overflow_err)
  );

  always #5 clk_in = ~clk_in;

  // Inputs change on negedges; outputs are sampled on negedges.
  task automatic do_reset();
    rst_in = 1'b0; rdy_in = 1'b1; mem_a = '0; mem_wr = 1'b0; mem_dout = '0;
    tx_ready = 1'b0; rx_valid = 1'b0; rx_data = '0;
    repeat (2) @(negedge clk_in);
    rst_in = 1'b1;
  endtask

  task automatic bus_write(input logic [31:0] a, input logic [7:0] d);
    mem_a = a; mem_dout = d; mem_wr = 1'b1;
    @(negedge clk_in);
    mem_a = '0; mem_dout = '0; mem_wr = 1'b0;
  endtask

  task automatic bus_read(input logic [31:0] a);
    mem_a = a; mem_wr = 1'b0;
    @(negedge clk_in);
    mem_a = '0;
  endtask

  task automatic test_reset();
    rst_in = 1'b0;
    repeat (2) @(negedge clk_in);
    n_chk++; if ({tx_valid, io_sel, io_buffer_full, program_done, overflow_err, rx_ack} !== 6'b0)
      $display("FAIL reset_flags got=%b exp=000000", {tx_valid, io_sel, io_buffer_full, program_done, overflow_err, rx_ack}); else n_pass++;
    n_chk++; if ({io_din, tx_data} !== 16'h0000)
      $display("FAIL reset_data got=%h exp=0000", {io_din, tx_data}); else n_pass++;
    rst_in = 1'b1;
  endtask

  task automatic test_tx_basic();
    do_reset();
    tx_ready = 1'b1;
    bus_write(32'h30000, 8'h41);
    n_chk++; if ({tx_valid, tx_data} !== {1'b1, 8'h41})
      $display("FAIL tx_first got=%b/%h exp=1/41", tx_valid, tx_data); else n_pass++;
    bus_write(32'h30000, 8'h42);
    n_chk++; if ({tx_valid, tx_data} !== {1'b1, 8'h42})
      $display("FAIL tx_second got=%b/%h exp=1/42", tx_valid, tx_data); else n_pass++;
    bus_write(32'h30000, 8'h00);
    n_chk++; if (tx_valid !== 1'b0)
      $display("FAIL tx_zero_ignored got=%b exp=0", tx_valid); else n_pass++;
    tx_ready = 1'b0;
  endtask

  task automatic test_fill_overflow();
    logic [7:0] exp_q [16];
    do_reset();
    for (int i = 0; i < 14; i++) begin
      bus_write(32'h30000, 8'h10 + 8'(i));
      if (i == 12) begin
        n_chk++; if (io_buffer_full !== 1'b0)
          $display("FAIL full_at13 got=%b exp=0", io_buffer_full); else n_pass++;
      end
    end
    n_chk++; if (io_buffer_full !== 1'b1)
      $display("FAIL full_at14 got=%b exp=1", io_buffer_full); else n_pass++;
    bus_write(32'h30000, 8'h1E);
    bus_write(32'h30000, 8'h1F);
    n_chk++; if ({io_buffer_full, overflow_err} !== 2'b10)
      $display("FAIL full16_no_err got=%b exp=10", {io_buffer_full, overflow_err}); else n_pass++;
    // push into a full FIFO while it pops: both must happen
    tx_ready = 1'b1;
    bus_write(32'h30000, 8'hA0);
    tx_ready = 1'b0;
    n_chk++; if ({overflow_err, io_buffer_full, tx_data} !== {2'b01, 8'h11})
      $display("FAIL push_pop_full got=%b%b/%h exp=01/11", overflow_err, io_buffer_full, tx_data); else n_pass++;
    bus_write(32'h30000, 8'h99);
    n_chk++; if (overflow_err !== 1'b1)
      $display("FAIL overflow_set got=%b exp=1", overflow_err); else n_pass++;
    for (int i = 0; i < 15; i++) exp_q[i] = 8'h11 + 8'(i);
    exp_q[15] = 8'hA0;
    tx_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      n_chk++; if ({tx_valid, tx_data} !== {1'b1, exp_q[i]})
        $display("FAIL drain_%0d got=%b/%h exp=1/%h", i, tx_valid, tx_data, exp_q[i]); else n_pass++;
      @(negedge clk_in);
    end
    n_chk++; if (tx_valid !== 1'b0)
      $display("FAIL drain_end got=%b exp=0", tx_valid); else n_pass++;
    tx_ready = 1'b0;
  endtask

  task automatic test_counter();
    logic [7:0] b [4];
    do_reset();
    repeat (1000) @(negedge clk_in);
    for (int i = 0; i < 4; i++) begin
      bus_read(32'h30004 + i);
      b[i] = io_din;
      n_chk++; if (io_sel !== 1'b1)
        $display("FAIL cnt_sel_%0d got=%b exp=1", i, io_sel); else n_pass++;
    end
    n_chk++; if ({b[3], b[2], b[1], b[0]} !== 32'd1000)
      $display("FAIL cnt_snapshot got=%0d exp=1000", {b[3], b[2], b[1], b[0]}); else n_pass++;
    @(negedge clk_in);
    n_chk++; if (io_sel !== 1'b0)
      $display("FAIL cnt_sel_idle got=%b exp=0", io_sel); else n_pass++;
    rdy_in = 1'b0;
    repeat (10) @(negedge clk_in);
    rdy_in = 1'b1;
    bus_read(32'h30004);
    n_chk++; if (io_din !== 8'hED)
      $display("FAIL cnt_frozen_b0 got=%h exp=ed", io_din); else n_pass++;
    bus_read(32'h30005);
    n_chk++; if (io_din !== 8'h03)
      $display("FAIL cnt_frozen_b1 got=%h exp=03", io_din); else n_pass++;
  endtask

  task automatic test_rx();
    do_reset();
    rx_valid = 1'b1; rx_data = 8'h5A;
    mem_a = 32'h30000; mem_wr = 1'b0;
    #1;
    n_chk++; if (rx_ack !== 1'b1)
      $display("FAIL rx_ack_pulse got=%b exp=1", rx_ack); else n_pass++;
    @(negedge clk_in);
    mem_a = '0; rx_valid = 1'b0; rx_data = '0;
    #1;
    n_chk++; if ({io_din, io_sel, rx_ack} !== {8'h5A, 2'b10})
      $display("FAIL rx_data got=%h/%b/%b exp=5a/1/0", io_din, io_sel, rx_ack); else n_pass++;
    @(negedge clk_in);
    mem_a = 32'h30000;
    #1;
    n_chk++; if (rx_ack !== 1'b0)
      $display("FAIL rx_no_ack got=%b exp=0", rx_ack); else n_pass++;
    @(negedge clk_in);
    mem_a = '0;
    n_chk++; if ({io_din, io_sel} !== {8'h00, 1'b1})
      $display("FAIL rx_empty got=%h/%b exp=00/1", io_din, io_sel); else n_pass++;
  endtask

  task automatic test_stop();
    logic [7:0] exp_q [4];
    exp_q[0] = 8'h01; exp_q[1] = 8'h02; exp_q[2] = 8'h03; exp_q[3] = 8'h00;
    do_reset();
    bus_write(32'h30000, 8'h01);
    bus_write(32'h30000, 8'h02);
    bus_write(32'h30000, 8'h03);
    bus_write(32'h30004, 8'hFF);
    bus_write(32'h30000, 8'h43);
    n_chk++; if ({overflow_err, program_done} !== 2'b00)
      $display("FAIL stop_flags got=%b exp=00", {overflow_err, program_done}); else n_pass++;
    tx_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      n_chk++; if ({tx_valid, tx_data} !== {1'b1, exp_q[i]})
        $display("FAIL stop_drain_%0d got=%b/%h exp=1/%h", i, tx_valid, tx_data, exp_q[i]); else n_pass++;
      @(negedge clk_in);
    end
    n_chk++; if ({tx_valid, program_done} !== 2'b00)
      $display("FAIL stop_empty got=%b exp=00", {tx_valid, program_done}); else n_pass++;
    @(negedge clk_in);
    n_chk++; if ({tx_valid, program_done} !== 2'b01)
      $display("FAIL stop_done got=%b exp=01", {tx_valid, program_done}); else n_pass++;
    rst_in = 1'b0;
    #1;
    n_chk++; if (program_done !== 1'b0)
      $display("FAIL done_reset got=%b exp=0", program_done); else n_pass++;
    @(negedge clk_in);
    rst_in = 1'b1;
    tx_ready = 1'b0;
  endtask

  task automatic test_reset_mid_drain();
    do_reset();
    for (int i = 0; i < 17; i++) bus_write(32'h30000, 8'h60 + 8'(i));
    tx_ready = 1'b1;
    repeat (2) @(negedge clk_in);
    n_chk++; if ({tx_valid, overflow_err, tx_data} !== {2'b11, 8'h62})
      $display("FAIL pre_reset got=%b%b/%h exp=11/62", tx_valid, overflow_err, tx_data); else n_pass++;
    #2 rst_in = 1'b0;
    #1;
    n_chk++; if ({tx_valid, program_done, overflow_err, io_buffer_full, tx_data} !== 12'h000)
      $display("FAIL mid_reset got=%b%b%b%b/%h exp=0000/00", tx_valid, program_done, overflow_err, io_buffer_full, tx_data); else n_pass++;
    @(negedge clk_in);
    rst_in = 1'b1;
    tx_ready = 1'b0;
  endtask

  initial begin
    test_reset();
    test_tx_basic();
    test_fill_overflow();
    test_counter();
    test_rx();
    test_stop();
    test_reset_mid_drain();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
